axi_lite_monitor: RTL

AXI_LITE_MONITOR -- requirements
Module: axi_lite_monitor

---
 rtl/axi_lite_monitor_if.sv | 38 +++
 rtl/axi_lite_monitor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/axi_lite_monitor_if.sv
// AXI-lite signal bundle. The monitor modport observes every signal and drives none.
interface axi_lite_monitor_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport monitor (
    input awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready,
          bresp, bvalid, bready, araddr, arprot, arvalid, arready,
          rdata, rresp, rvalid, rready
  );
endinterface

// File: rtl/axi_lite_monitor.sv
// Passive AXI-lite protocol checker: payload stability, orphan/overflow responses,
// VALID-wait timeouts, outstanding counters and completion statistics.
module axi_lite_monitor #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16,
  parameter int MAX_OUT  = 4,
  localparam int PW      = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  axi_lite_monitor_if.monitor bus,
  output logic                err_valid,
  output logic [2:0]          err_code,
  output logic [7:0]          err_sticky,
  output logic [15:0]         err_count,
  output logic [15:0]         wr_done,
  output logic [15:0]         rd_done,
  output logic [PW-1:0]       aw_pend,
  output logic [PW-1:0]       w_pend,
  output logic [PW-1:0]       ar_pend
);
  localparam int            TW        = $clog2(MAX_WAIT + 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_OUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(MAX_WAIT - 1);
  localparam logic [TW-1:0] WAIT_MAX  = TW'(MAX_WAIT);

  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] cur,
                                               input logic inc, input logic dec);
    logic [PW-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != PEND_MAX) nxt = cur + PW'(1);
    else if (dec && !inc)               nxt = cur - PW'(1);
    return nxt;
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // Channel bit order equals check index: 0 AW, 1 W, 2 AR, 3 B, 4 R.
  logic [4:0] vld, rdy, stall, hs, changed;
  assign vld   = {bus.rvalid, bus.bvalid, bus.arvalid, bus.wvalid, bus.awvalid};
  assign rdy   = {bus.rready, bus.bready, bus.arready, bus.wready, bus.awready};
  assign stall = vld & ~rdy;
  assign hs    = vld & rdy;

  logic [ADDR_W+2:0]          aw_pl_d, aw_pl_q, ar_pl_d, ar_pl_q;
  logic [DATA_W+DATA_W/8-1:0] w_pl_d, w_pl_q;
  logic [1:0]                 b_pl_d, b_pl_q;
  logic [DATA_W+1:0]          r_pl_d, r_pl_q;

  logic [4:0]         hold_d, hold_q;
  logic [4:0][TW-1:0] to_cnt_d, to_cnt_q;
  logic [PW-1:0]      aw_pend_d, aw_pend_q, w_pend_d, w_pend_q, ar_pend_d, ar_pend_q;
  logic               err_valid_d, err_valid_q;
  logic [2:0]         err_code_d, err_code_q;
  logic [7:0]         err_sticky_d, err_sticky_q;
  logic [15:0]        err_count_d, err_count_q, wr_done_d, wr_done_q, rd_done_d, rd_done_q;

  logic       aw_dec, w_dec, ar_dec, b_ok, r_ok;
  logic [7:0] viol;

  always_comb begin
    aw_pl_d = {bus.awprot, bus.awaddr};
    w_pl_d  = {bus.wstrb, bus.wdata};
    ar_pl_d = {bus.arprot, bus.araddr};
    b_pl_d  = bus.bresp;
    r_pl_d  = {bus.rresp, bus.rdata};
    changed = {r_pl_d != r_pl_q, b_pl_d != b_pl_q, ar_pl_d != ar_pl_q,
               w_pl_d != w_pl_q, aw_pl_d != aw_pl_q};

    // Responses are judged against the registered counts only.
    aw_dec = hs[3] && (aw_pend_q != '0);
    w_dec  = hs[3] && (w_pend_q != '0);
    ar_dec = hs[4] && (ar_pend_q != '0);
    b_ok   = aw_dec && w_dec;
    r_ok   = ar_dec;

    viol      = '0;
    viol[4:0] = hold_q & (~vld | changed);
    viol[5]   = (hs[3] && !b_ok) || (hs[4] && !r_ok);
    viol[6]   = (hs[0] && aw_pend_q == PEND_MAX && !aw_dec) ||
                (hs[1] && w_pend_q  == PEND_MAX && !w_dec)  ||
                (hs[2] && ar_pend_q == PEND_MAX && !ar_dec);

    // Wait counters saturate at MAX_WAIT so each stall flags exactly once.
    to_cnt_d = to_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (stall[i] && to_cnt_q[i] == WAIT_LAST) viol[7] = 1'b1;
      if (!stall[i])                     to_cnt_d[i] = '0;
      else if (to_cnt_q[i] != WAIT_MAX)  to_cnt_d[i] = to_cnt_q[i] + TW'(1);
    end

    hold_d    = stall;
    aw_pend_d = pend_next(aw_pend_q, hs[0], aw_dec);
    w_pend_d  = pend_next(w_pend_q,  hs[1], w_dec);
    ar_pend_d = pend_next(ar_pend_q, hs[2], ar_dec);

    err_valid_d = |viol;
    if (clear) begin
      err_sticky_d = viol;
      err_count_d  = {15'd0, |viol};
      err_code_d   = (|viol) ? lowest(viol) : 3'd0;
      wr_done_d    = '0;
      rd_done_d    = '0;
    end else begin
      err_sticky_d = err_sticky_q | viol;
      err_count_d  = ((|viol) && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
      err_code_d   = (|viol) ? lowest(viol) : err_code_q;
      wr_done_d    = wr_done_q + 16'(b_ok);
      rd_done_d    = rd_done_q + 16'(r_ok);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q       <= '0;
      to_cnt_q     <= '0;
      aw_pend_q    <= '0;
      w_pend_q     <= '0;
      ar_pend_q    <= '0;
      err_valid_q  <= 1'b0;
      err_code_q   <= '0;
      err_sticky_q <= '0;
      err_count_q  <= '0;
      wr_done_q    <= '0;
      rd_done_q    <= '0;
    end else begin
      hold_q       <= hold_d;
      to_cnt_q     <= to_cnt_d;
      aw_pend_q    <= aw_pend_d;
      w_pend_q     <= w_pend_d;
      ar_pend_q    <= ar_pend_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
    end
  end

  // Payload snapshots are only consulted when hold_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    aw_pl_q <= aw_pl_d;
    w_pl_q  <= w_pl_d;
    ar_pl_q <= ar_pl_d;
    b_pl_q  <= b_pl_d;
    r_pl_q  <= r_pl_d;
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign wr_done    = wr_done_q;
  assign rd_done    = rd_done_q;
  assign aw_pend    = aw_pend_q;
  assign w_pend     = w_pend_q;
  assign ar_pend    = ar_pend_q;
endmodule
